// File: rtl/reset_sequencer_if.sv
// Request/status bundle between the reset sequencer and the control register block.
interface reset_sequencer_if #(
    parameter int unsigned NUM_OUT = 3
);
    logic               swReq;
    logic               wdogExpire;
    logic               holdReq;
    logic [NUM_OUT-1:0] rstOut;
    logic               busy;
    logic               done;
    logic [3:0]         cause;

    modport master (
        output swReq, wdogExpire, holdReq,
        input  rstOut, busy, done, cause
    );

    modport slave (
        input  swReq, wdogExpire, holdReq,
        output rstOut, busy, done, cause
    );
endinterface

// File: rtl/reset_sequencer.sv
// Stretches power-on/software/watchdog/hold reset requests and releases the
// reset outputs one by one in index order, reporting busy/done and the cause.
module reset_sequencer #(
    parameter int unsigned NUM_OUT    = 3,
    parameter int unsigned MIN_ASSERT = 16,
    parameter int unsigned STAGE_GAP  = 4
) (
    input logic              clk,
    input logic              rst,
    reset_sequencer_if.slave bus
);
    localparam int unsigned CNT_SPAN = (MIN_ASSERT > STAGE_GAP) ? MIN_ASSERT : STAGE_GAP;
    localparam int unsigned CNT_W    = $clog2(CNT_SPAN) + 1;
    localparam int unsigned IDX_W    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(MIN_ASSERT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_OUT - 1);

    typedef enum logic [1:0] {IDLE, ASSERT, RELEASE, DONE} stateT;

    stateT              state,     stateNxt;
    logic [CNT_W-1:0]   cnt,       cntNxt;
    logic [IDX_W-1:0]   idx,       idxNxt;
    logic [NUM_OUT-1:0] rstOutQ,   rstOutNxt;
    logic               busyQ,     busyNxt;
    logic               doneQ,     doneNxt;
    logic [3:0]         causeQ,    causeNxt;

    logic [3:0] reqBits;
    logic       anyReq;
    logic       restartSeq;

    assign reqBits = {bus.holdReq, bus.wdogExpire, bus.swReq, 1'b0};
    assign anyReq  = bus.swReq | bus.wdogExpire | bus.holdReq;
    // holdReq inside ASSERT only extends the assert window; it does not restart it
    assign restartSeq = (state != IDLE) &&
                        (bus.swReq || bus.wdogExpire || (bus.holdReq && state != ASSERT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ASSERT;
            cnt     <= '0;
            idx     <= '0;
            rstOutQ <= '1;
            busyQ   <= 1'b1;
            doneQ   <= 1'b0;
            causeQ  <= 4'b0001;
        end else begin
            state   <= stateNxt;
            cnt     <= cntNxt;
            idx     <= idxNxt;
            rstOutQ <= rstOutNxt;
            busyQ   <= busyNxt;
            doneQ   <= doneNxt;
            causeQ  <= causeNxt;
        end
    end

    always_comb begin
        stateNxt  = state;
        cntNxt    = cnt;
        idxNxt    = idx;
        rstOutNxt = rstOutQ;
        causeNxt  = causeQ;

        if (restartSeq) begin
            stateNxt  = ASSERT;
            cntNxt    = '0;
            idxNxt    = '0;
            rstOutNxt = '1;
            causeNxt  = causeQ | reqBits;
        end else begin
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        stateNxt  = ASSERT;
                        cntNxt    = '0;
                        idxNxt    = '0;
                        rstOutNxt = '1;
                        causeNxt  = reqBits;
                    end
                end
                ASSERT: begin
                    causeNxt = causeQ | reqBits;
                    if (cnt >= ASSERT_LAST && !bus.holdReq) begin
                        stateNxt = RELEASE;
                        cntNxt   = '0;
                        idxNxt   = '0;
                    end else if (cnt != CNT_MAX) begin
                        cntNxt = cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (cnt == GAP_LAST) begin
                        cntNxt    = '0;
                        rstOutNxt = rstOutQ & ~(NUM_OUT'(1) << idx);
                        if (idx == IDX_LAST) begin
                            stateNxt = DONE;
                        end else begin
                            idxNxt = idx + IDX_W'(1);
                        end
                    end else begin
                        cntNxt = cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    stateNxt = IDLE;
                end
                default: begin
                    stateNxt = IDLE;
                end
            endcase
        end

        busyNxt = (stateNxt != IDLE);
        doneNxt = (stateNxt == DONE);
    end

    assign bus.rstOut = rstOutQ;
    assign bus.busy   = busyQ;
    assign bus.done   = doneQ;
    assign bus.cause  = causeQ;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed and randomized checks of reset_sequencer against a timeline model of
// when each output should release, derived from request/hold sample edges.
module tb_reset_sequencer;
    localparam int NUM_OUT    = 3;
    localparam int MIN_ASSERT = 16;
    localparam int STAGE_GAP  = 4;

    logic clk = 1'b0;
    logic rst;

    reset_sequencer_if #(.NUM_OUT(NUM_OUT)) bus ();

    reset_sequencer #(
        .NUM_OUT   (NUM_OUT),
        .MIN_ASSERT(MIN_ASSERT),
        .STAGE_GAP (STAGE_GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int donePulses = 0;

    // Model: edge counter, edge the current sequence (re)started, edge release began
    int       n;
    int       startEdge;
    int       relEdge;
    bit       active;
    logic [3:0] mCause;

    task automatic modelReset();
        n         = 0;
        startEdge = 0;
        relEdge   = -1;
        active    = 1'b1;
        mCause    = 4'b0001;
    endtask

    task automatic modelEdge(input logic sw, input logic wd, input logic hd);
        logic [3:0] bits;
        bits = {hd, wd, sw, 1'b0};
        n++;
        if (!active) begin
            if (sw || wd || hd) begin
                active    = 1'b1;
                startEdge = n;
                relEdge   = -1;
                mCause    = bits;
            end
        end else begin
            mCause = mCause | bits;
            if (sw || wd) begin
                startEdge = n;
                relEdge   = -1;
            end else if (relEdge < 0) begin
                if (n >= startEdge + MIN_ASSERT && !hd) relEdge = n;
            end else if (hd) begin
                startEdge = n;
                relEdge   = -1;
            end else if (n == relEdge + STAGE_GAP * NUM_OUT + 1) begin
                active = 1'b0;
            end
        end
    endtask

    task automatic checkAll(input string tag);
        logic [NUM_OUT-1:0] er;
        logic eb, ed;
        int e;
        if (!active) begin
            er = '0; eb = 1'b0; ed = 1'b0;
        end else if (relEdge < 0) begin
            er = '1; eb = 1'b1; ed = 1'b0;
        end else begin
            e = n - relEdge;
            for (int k = 0; k < NUM_OUT; k++) er[k] = (e < STAGE_GAP * (k + 1));
            eb = 1'b1;
            ed = (e == STAGE_GAP * NUM_OUT);
        end
        checks++;
        assert (bus.rstOut === er) else begin
            errors++;
            $error("FAIL %s rstOut edge %0d: observed %b expected %b", tag, n, bus.rstOut, er);
        end
        checks++;
        assert (bus.busy === eb) else begin
            errors++;
            $error("FAIL %s busy edge %0d: observed %b expected %b", tag, n, bus.busy, eb);
        end
        checks++;
        assert (bus.done === ed) else begin
            errors++;
            $error("FAIL %s done edge %0d: observed %b expected %b", tag, n, bus.done, ed);
        end
        checks++;
        assert (bus.cause === mCause) else begin
            errors++;
            $error("FAIL %s cause edge %0d: observed %b expected %b", tag, n, bus.cause, mCause);
        end
        if (bus.done === 1'b1) donePulses++;
    endtask

    task automatic checkResetVals(input string tag);
        logic [NUM_OUT-1:0] ones;
        ones = '1;
        checks++;
        assert (bus.rstOut === ones) else begin
            errors++;
            $error("FAIL %s rstOut: observed %b expected %b", tag, bus.rstOut, ones);
        end
        checks++;
        assert (bus.busy === 1'b1) else begin
            errors++;
            $error("FAIL %s busy: observed %b expected 1", tag, bus.busy);
        end
        checks++;
        assert (bus.done === 1'b0) else begin
            errors++;
            $error("FAIL %s done: observed %b expected 0", tag, bus.done);
        end
        checks++;
        assert (bus.cause === 4'b0001) else begin
            errors++;
            $error("FAIL %s cause: observed %b expected 0001", tag, bus.cause);
        end
    endtask

    task automatic checkDoneCount(input string tag, input int exp);
        checks++;
        assert (donePulses === exp) else begin
            errors++;
            $error("FAIL %s done pulse count: observed %0d expected %0d", tag, donePulses, exp);
        end
    endtask

    // Called at a negedge: drive inputs, sample at the next posedge, check just after it
    task automatic step(input logic sw, input logic wd, input logic hd, input string tag);
        bus.swReq      = sw;
        bus.wdogExpire = wd;
        bus.holdReq    = hd;
        @(posedge clk);
        modelEdge(sw, wd, hd);
        #1;
        checkAll(tag);
        @(negedge clk);
    endtask

    task automatic idle(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic releaseReset();
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        int holdLeft;
        logic sw, wd, hd;

        bus.swReq      = 1'b0;
        bus.wdogExpire = 1'b0;
        bus.holdReq    = 1'b0;
        rst            = 1'b1;
        #1;
        checkResetVals("por_reset");
        releaseReset();
        idle(35, "por");

        // Single-cycle software pulse from IDLE
        step(1'b1, 1'b0, 1'b0, "sw_pulse");
        idle(35, "sw_seq");

        // Long hold from IDLE
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b1, "hold");
        idle(20, "hold_release");

        // Watchdog arrives once rstOut is 110
        donePulses = 0;
        step(1'b1, 1'b0, 1'b0, "restart_sw");
        idle(20, "restart_pre");
        step(1'b0, 1'b1, 1'b0, "restart_wdog");
        idle(33, "restart_post");
        checkDoneCount("restart", 1);

        // Asynchronous reset between edges while in RELEASE
        step(1'b1, 1'b0, 1'b0, "midrst_sw");
        idle(22, "midrst_pre");
        rst = 1'b1;
        #1;
        checkResetVals("midrst_async");
        releaseReset();
        idle(35, "midrst_por");

        // Simultaneous sw and wdog from IDLE
        donePulses = 0;
        step(1'b1, 1'b1, 1'b0, "simul");
        idle(35, "simul_seq");
        checkDoneCount("simul", 1);

        // Randomized request mix
        holdLeft = 0;
        for (int i = 0; i < 800; i++) begin
            sw = ($urandom_range(0, 49) == 0);
            wd = ($urandom_range(0, 69) == 0);
            if (holdLeft == 0 && $urandom_range(0, 79) == 0) holdLeft = $urandom_range(1, 30);
            hd = (holdLeft > 0);
            if (holdLeft > 0) holdLeft--;
            step(sw, wd, hd, "random");
        end
        idle(40, "drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed time %0t expected below 200000", $time);
        $fatal(1, "timeout");
    end
endmodule
